// File: rtl/uart16_pkg.sv
// uart16_pkg: shared definitions for the uart16 transmit path.
//   lcr_t        : line-control fields {brk, eps, pen, stb, wls[1:0]}
//   ST_*         : serialiser FSM state encodings
//   STOP_TICKS_* : stop-bit lengths in 16x ticks (1, 1.5, 2 stop bits)
//   last_bit()   : index of the final data bit for a word length select
//   word_mask()  : mask of the data bits actually sent
//   stop_last()  : final stop tick index for a latched frame format
package uart16_pkg;

    typedef struct packed {
        logic       brk;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [5:0] STOP_TICKS_1  = 6'd16;
    localparam logic [5:0] STOP_TICKS_15 = 6'd24;
    localparam logic [5:0] STOP_TICKS_2  = 6'd32;

    // wls 0..3 selects 5..8 data bits, so the last index is 4..7.
    function automatic logic [2:0] last_bit(input logic [1:0] wls);
        return 3'd4 + {1'b0, wls};
    endfunction

    function automatic logic [7:0] word_mask(input logic [1:0] wls);
        return 8'hFF >> (3'd3 - {1'b0, wls});
    endfunction

    // 1.5 stop bits only exist for 5-bit words; other lengths get 2.
    function automatic logic [4:0] stop_last(input lcr_t f);
        logic [5:0] ticks;
        if (!f.stb)            ticks = STOP_TICKS_1;
        else if (f.wls == 2'd0) ticks = STOP_TICKS_15;
        else                   ticks = STOP_TICKS_2;
        return 5'(ticks - 6'd1);
    endfunction

endpackage

// File: rtl/uart16_baud_gen.sv
// uart16_baud_gen: 16x baud tick generator.
//   clk       : uart clock
//   rst       : synchronous reset, active-high
//   en_i      : run enable (synchronised PLL lock); low holds the counter cleared
//   divisor_i : baud divisor; 0 stops ticks, 1 ticks every cycle
//   baudout_o : one-cycle 16x tick
module uart16_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [15:0] divisor_i,
    output logic        baudout_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    // The divisor is only consulted on reload, so a new value never
    // shortens the period in flight and cannot produce a glitch tick.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (divisor_i == 16'd0) begin
            cnt_d = 16'd0;
        end else if (cnt_q == 16'd0) begin
            tick_d = 1'b1;
            cnt_d  = divisor_i - 16'd1;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            cnt_q  <= 16'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign baudout_o = tick_q && en_i;

endmodule

// File: rtl/uart16_tx_core.sv
// uart16_tx_core: 16550-style transmit path (baud generator, TX FIFO, serialiser).
//   clk        : uart clock (PLL output)
//   rst        : synchronous reset, active-high
//   pll_locked : PLL lock, asynchronous to clk
//   divisor    : baud divisor latch; baud = clk/(16*divisor)
//   lcr        : {brk, eps, pen, stb, wls[1:0]}
//   tx_data    : byte to queue, tx_valid/tx_ready handshake
//   txd        : serial output, idle high
//   baudout    : 16x baud tick
//   thre/temt  : FIFO empty / FIFO empty and shifter idle
//   fifo_level : entries held
module uart16_tx_core
    import uart16_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LOCK_SYNC  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pll_locked,
    input  logic [15:0]                   divisor,
    input  logic [5:0]                    lcr,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          baudout,
    output logic                          thre,
    output logic                          temt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Lock synchroniser; losing lock behaves like a reset of everything downstream.
    logic [LOCK_SYNC-1:0] sync_q;
    logic                 lock_s;
    logic                 clr;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= (LOCK_SYNC)'({sync_q, pll_locked});
    end

    assign lock_s = sync_q[LOCK_SYNC-1];
    assign clr    = rst || !lock_s;

    logic tick;

    uart16_baud_gen u_baud (
        .clk       (clk),
        .rst       (rst),
        .en_i      (lock_s),
        .divisor_i (divisor),
        .baudout_o (tick)
    );

    assign baudout = tick;

    // TX FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   lvl_q, lvl_d;
    logic          push, pop, empty, full;

    assign empty    = (lvl_q == '0);
    assign full     = (lvl_q == (AW+1)'(FIFO_DEPTH));
    assign tx_ready = lock_s && !full;
    assign push     = tx_valid && tx_ready;

    always_comb begin
        lvl_d = lvl_q;
        unique case ({push, pop})
            2'b10:   lvl_d = lvl_q + (AW+1)'(1);
            2'b01:   lvl_d = lvl_q - (AW+1)'(1);
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
        end
    end

    // Serialiser FSM; all progress is paced by the 16x tick.
    logic [2:0] state_q, state_d;
    logic [4:0] tcnt_q, tcnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q;
    lcr_t       frm_q;
    logic       load;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        load    = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        state_d = ST_START;
                        tcnt_d  = 5'd0;
                    end
                end
                ST_START: begin
                    if (tcnt_q == 5'd15) begin
                        state_d = ST_DATA;
                        tcnt_d  = 5'd0;
                        bit_d   = 3'd0;
                    end else begin
                        tcnt_d = tcnt_q + 5'd1;
                    end
                end
                ST_DATA: begin
                    if (tcnt_q == 5'd15) begin
                        tcnt_d = 5'd0;
                        if (bit_q == last_bit(frm_q.wls)) state_d = frm_q.pen ? ST_PARITY : ST_STOP;
                        else                              bit_d   = bit_q + 3'd1;
                    end else begin
                        tcnt_d = tcnt_q + 5'd1;
                    end
                end
                ST_PARITY: begin
                    if (tcnt_q == 5'd15) begin
                        state_d = ST_STOP;
                        tcnt_d  = 5'd0;
                    end else begin
                        tcnt_d = tcnt_q + 5'd1;
                    end
                end
                ST_STOP: begin
                    if (tcnt_q == stop_last(frm_q)) begin
                        tcnt_d = 5'd0;
                        // Back-to-back frames skip IDLE so there is no idle gap.
                        if (!empty) begin
                            pop     = 1'b1;
                            load    = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 5'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            tcnt_q  <= 5'd0;
            bit_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bit_q   <= bit_d;
        end
    end

    // Frame format is captured with the byte so lcr edits only affect later frames.
    always_ff @(posedge clk) begin
        if (load) begin
            shift_q <= mem_q[rd_q];
            frm_q   <= lcr_t'(lcr);
        end
    end

    logic par;
    logic line;

    // eps=0 gives odd parity (inverted XOR), eps=1 even.
    assign par = (^(shift_q & word_mask(frm_q.wls))) ^ ~frm_q.eps;

    always_comb begin
        line = 1'b1;
        unique case (state_q)
            ST_START:  line = 1'b0;
            ST_DATA:   line = shift_q[bit_q];
            ST_PARITY: line = par;
            default:   line = 1'b1;
        endcase
    end

    // Break is live from the register file and overrides the frame without stalling it.
    assign txd        = !lcr[5] && (!lock_s || line);
    assign fifo_level = lock_s ? lvl_q : '0;
    assign thre       = (fifo_level == '0);
    assign temt       = thre && (!lock_s || state_q == ST_IDLE);

endmodule

// File: tb/tb_uart16_tx_core.sv
module tb_uart16_tx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        pll_locked;
    logic [15:0] divisor;
    logic [5:0]  lcr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        txd;
    logic        baudout;
    logic        thre;
    logic        temt;
    logic [4:0]  fifo_level;

    uart16_tx_core dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .divisor    (divisor),
        .lcr        (lcr),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .baudout    (baudout),
        .thre       (thre),
        .temt       (temt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         nb;
        bit         pen;
        bit         par;
        int         p;
        int         stop_clks;
    } frame_t;

    frame_t exp_q[$];
    int     start_q[$];
    bit     mon_en   = 1'b0;
    bit     mon_busy = 1'b0;
    int     n_pass   = 0;
    int     n_total  = 0;
    int     push_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Scoreboard monitor: decodes each frame on txd and compares it with the
    // oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                int t0;
                t0 = cyc;
                mon_busy = 1'b1;
                start_q.push_back(t0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    for (int w = 0; w < 5000 && txd !== 1'b1; w++) @(negedge clk);
                end else begin
                    frame_t e;
                    logic [7:0] got;
                    logic       gpar;
                    bit         start_ok, stop_ok;
                    int         s, last;
                    e        = exp_q.pop_front();
                    got      = 8'h00;
                    gpar     = 1'b0;
                    start_ok = 1'b1;
                    stop_ok  = 1'b1;
                    s        = (1 + e.nb + (e.pen ? 1 : 0)) * e.p;
                    last     = s + e.stop_clks - 1;
                    for (int o = 1; o <= last; o++) begin
                        @(negedge clk);
                        if (o < e.p && txd !== 1'b0) start_ok = 1'b0;
                        if (o >= e.p && o < (1 + e.nb) * e.p && (o % e.p) == e.p / 2)
                            got[(o / e.p) - 1] = txd;
                        if (e.pen && o == (1 + e.nb) * e.p + e.p / 2) gpar = txd;
                        if (o >= s && txd !== 1'b1) stop_ok = 1'b0;
                    end
                    chk("frame_start", start_ok, 1);
                    chk("frame_data", got, e.data);
                    if (e.pen) chk("frame_parity", gpar, e.par);
                    chk("frame_stop", stop_ok, 1);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic expect_frame(input logic [7:0] d, input int nb, input bit pen, input bit par,
                                input int p, input int stop_clks);
        frame_t f;
        f.data = d; f.nb = nb; f.pen = pen; f.par = par; f.p = p; f.stop_clks = stop_clks;
        exp_q.push_back(f);
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic drain(input string nm, input int lim);
        int n;
        n = 0;
        while (!(temt === 1'b1 && exp_q.size() == 0 && !mon_busy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (n < lim), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_start(output int t0);
        int n;
        n = 0;
        @(negedge clk);
        while (txd !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", (txd === 1'b0), 1);
        t0 = cyc;
    endtask

    task automatic wait_to(input int t0, input int off);
        while (cyc - t0 < off) @(negedge clk);
    endtask

    logic [7:0] burst [17] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h12,
                               8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h7E};

    initial begin
        int t0, k0, bad, bcnt, lowcnt;
        int tk[3];

        rst = 1'b1; pll_locked = 1'b0; divisor = 16'd1; lcr = 6'b000011;
        tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_baudout", baudout, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_thre", thre, 1);
        chk("rst_temt", temt, 1);
        chk("rst_level", fifo_level, 0);

        rst = 1'b0; pll_locked = 1'b1;
        repeat (4) @(negedge clk);
        chk("lock_tx_ready", tx_ready, 1);

        // 1: 8N1 at divisor 1, byte 0x55
        mon_en = 1'b1;
        k0 = start_q.size();
        expect_frame(8'h55, 8, 0, 0, 16, 16);
        push(8'h55);
        drain("t1_drain", 1000);
        chk("t1_latency", (start_q.size() > k0 && start_q[k0] - push_cyc <= 2), 1);
        chk("t1_temt", temt, 1);

        // 2: 7E2 at divisor 12, byte 0x41 -> data 1000001, even parity 0
        divisor = 16'd12; lcr = 6'b011110;
        expect_frame(8'h41, 7, 1, 0, 192, 384);
        push(8'h41);
        drain("t2_drain", 4000);

        // 3: 17 bytes back-to-back, 8N1 at divisor 1
        divisor = 16'd1; lcr = 6'b000011;
        repeat (4) @(negedge clk);
        k0 = start_q.size();
        for (int i = 0; i < 17; i++) begin
            expect_frame(burst[i], 8, 0, 0, 16, 16);
            push(burst[i]);
        end
        @(negedge clk);
        chk("t3_level_full", fifo_level, 16);
        chk("t3_ready_low", tx_ready, 0);
        drain("t3_drain", 4000);
        bad = 0;
        for (int i = 1; i < 17; i++)
            if (start_q.size() <= k0 + i || start_q[k0 + i] - start_q[k0 + i - 1] != 160) bad++;
        chk("t3_contiguous", bad, 0);
        chk("t3_level_end", fifo_level, 0);

        // 4: lock lost mid-frame with bytes still queued
        mon_en = 1'b0;
        push(8'hA5); push(8'h3C); push(8'h0F);
        wait_start(t0);
        wait_to(t0, 40);
        pll_locked = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("t4_txd", txd, 1);
        chk("t4_level", fifo_level, 0);
        chk("t4_ready", tx_ready, 0);
        chk("t4_temt", temt, 1);
        lowcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lowcnt++;
        end
        chk("t4_txd_held", lowcnt, 0);
        @(negedge clk);
        pll_locked = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("t4_relock_ready", tx_ready, 1);
        chk("t4_relock_level", fifo_level, 0);
        chk("t4_relock_txd", txd, 1);
        mon_en = 1'b1;
        expect_frame(8'h81, 8, 0, 0, 16, 16);
        push(8'h81);
        drain("t4_drain", 1000);

        // 5: divisor 0 freezes everything, divisor 3 restarts it
        @(negedge clk);
        divisor = 16'd0;
        repeat (3) @(negedge clk);
        expect_frame(8'h33, 8, 0, 0, 48, 48);
        push(8'h33);
        bcnt = 0; lowcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (baudout === 1'b1) bcnt++;
            if (txd !== 1'b1) lowcnt++;
        end
        chk("t5_no_tick", bcnt, 0);
        chk("t5_txd_idle", lowcnt, 0);
        chk("t5_level", fifo_level, 1);
        divisor = 16'd3;
        for (int j = 0; j < 3; j++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (baudout !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            tk[j] = cyc;
        end
        chk("t5_tick_gap1", tk[1] - tk[0], 3);
        chk("t5_tick_gap2", tk[2] - tk[1], 3);
        drain("t5_drain", 3000);

        // 6: live break on a 5-bit, 1.5-stop frame of 0x15 (bits 1,0,1,0,1)
        @(negedge clk);
        divisor = 16'd1; lcr = 6'b000100;
        mon_en = 1'b0;
        repeat (4) @(negedge clk);
        push(8'h15);
        wait_start(t0);
        wait_to(t0, 20);
        chk("t6_bit0", txd, 1);
        lcr = 6'b100100;
        #1;
        chk("t6_brk_low", txd, 0);
        wait_to(t0, 52);
        lcr = 6'b000100;
        #1;
        chk("t6_bit2_after_brk", txd, 1);
        wait_to(t0, 72);
        chk("t6_bit3", txd, 0);
        wait_to(t0, 88);
        chk("t6_bit4", txd, 1);
        wait_to(t0, 119);
        chk("t6_stop_txd", txd, 1);
        chk("t6_stop_not_done", temt, 0);
        wait_to(t0, 120);
        chk("t6_stop_24", temt, 1);

        repeat (4) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
